ad_bus_master: RTL and testbench

AD_BUS_MASTER -- requirements
Module: ad_bus_master

---
 rtl/ad_bus_pkg.sv | 25 ++
 rtl/ad_bus_if.sv | 30 +++
 rtl/ad_bus_master.sv | 153 +++++++++++++++
 tb/tb_ad_bus_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_bus_pkg.sv
// Shared widths, state encoding and phase-timing defaults for the multiplexed A/D bus master.
package ad_bus_pkg;

  localparam int DEF_ALE_CYCLES  = 1;
  localparam int DEF_WAIT_CYCLES = 2;
  localparam int CNT_W           = 4;
  localparam int ADDR_W          = 16;
  localparam int DATA_W          = 8;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    HOLD,
    ACCESS,
    RECOVER
  } state_e;

  // Preload for a phase lasting n cycles; the counter runs down to zero.
  function automatic cnt_t phase_load(input int n);
    return cnt_t'(n - 1);
  endfunction

endpackage

// File: rtl/ad_bus_if.sv
// Host request/response handshake plus the multiplexed address/data bus pins.
interface ad_bus_if;
  import ad_bus_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [DATA_W-1:0] ad_out;
  logic              ad_oe;
  logic [DATA_W-1:0] ad_in;
  logic [DATA_W-1:0] a_hi;
  logic              ale;
  logic              rd_b;
  logic              wr_b;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, ad_in,
    output req_ready, rsp_valid, rsp_rdata, ad_out, ad_oe, a_hi, ale, rd_b, wr_b
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, ad_in,
    input  req_ready, rsp_valid, rsp_rdata, ad_out, ad_oe, a_hi, ale, rd_b, wr_b
  );

endinterface

// File: rtl/ad_bus_master.sv
// Multiplexed A/D bus master: ALE address phase, address hold, timed RD/WR strobe, recovery.
// All bus outputs are registered so the pins never glitch between states.
module ad_bus_master
  import ad_bus_pkg::*;
#(
  parameter int ALE_CYCLES  = DEF_ALE_CYCLES,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic     clk,
  input  logic     rst_b,
  ad_bus_if.master bus
);

  localparam cnt_t ALE_LOAD  = phase_load(ALE_CYCLES);
  localparam cnt_t WAIT_LOAD = phase_load(WAIT_CYCLES + 1);

  state_e            state_q,     state_d;
  cnt_t              cnt_q,       cnt_d;
  logic              write_q,     write_d;
  logic [DATA_W-1:0] wdata_q,     wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [DATA_W-1:0] ad_out_q,    ad_out_d;
  logic              ad_oe_q,     ad_oe_d;
  logic [DATA_W-1:0] a_hi_q,      a_hi_d;
  logic              ale_q,       ale_d;
  logic              rd_b_q,      rd_b_d;
  logic              wr_b_q,      wr_b_d;

  // Next-state and next-output logic; outputs are decoded for the state being entered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    ad_out_d    = ad_out_q;
    ad_oe_d     = ad_oe_q;
    a_hi_d      = a_hi_q;
    ale_d       = ale_q;
    rd_b_d      = rd_b_q;
    wr_b_d      = wr_b_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d     = ADDR;
          cnt_d       = ALE_LOAD;
          write_d     = bus.req_write;
          wdata_d     = bus.req_wdata;
          req_ready_d = 1'b0;
          ad_out_d    = bus.req_addr[DATA_W-1:0];
          a_hi_d      = bus.req_addr[ADDR_W-1:DATA_W];
          ad_oe_d     = 1'b1;
          ale_d       = 1'b1;
        end
      end
      ADDR: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          ale_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        state_d = ACCESS;
        cnt_d   = WAIT_LOAD;
        if (write_q) begin
          ad_out_d = wdata_q;
          wr_b_d   = 1'b0;
        end else begin
          ad_oe_d = 1'b0;
          rd_b_d  = 1'b0;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d     = RECOVER;
          rd_b_d      = 1'b1;
          wr_b_d      = 1'b1;
          rsp_valid_d = 1'b1;
          ad_oe_d     = write_q;
          // Read data is captured at the end of the final strobe-low cycle.
          if (!write_q) begin
            rsp_rdata_d = bus.ad_in;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RECOVER: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        ad_oe_d     = 1'b0;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
        ad_oe_d     = 1'b0;
        ale_d       = 1'b0;
        rd_b_d      = 1'b1;
        wr_b_d      = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ad_out_q    <= '0;
      ad_oe_q     <= 1'b0;
      a_hi_q      <= '0;
      ale_q       <= 1'b0;
      rd_b_q      <= 1'b1;
      wr_b_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      wdata_q     <= wdata_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ad_out_q    <= ad_out_d;
      ad_oe_q     <= ad_oe_d;
      a_hi_q      <= a_hi_d;
      ale_q       <= ale_d;
      rd_b_q      <= rd_b_d;
      wr_b_q      <= wr_b_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.ad_out    = ad_out_q;
  assign bus.ad_oe     = ad_oe_q;
  assign bus.a_hi      = a_hi_q;
  assign bus.ale       = ale_q;
  assign bus.rd_b      = rd_b_q;
  assign bus.wr_b      = wr_b_q;

endmodule

// File: tb/tb_ad_bus_master.sv
// Bench for ad_bus_master: default-timing and ALE=3/WAIT=0 instances, vector table plus
// scoreboard, external address latch model, reset and back-to-back sequences.
module tb_ad_bus_master;

  localparam int A0 = 1;
  localparam int W0 = 2;
  localparam int A1 = 3;
  localparam int W1 = 0;

  typedef struct {
    int          id;
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  exp_rdata;
    int          exp_lat;
    int          exp_ale;
    int          exp_strb;
  } txn_t;

  typedef struct {
    logic        write;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdin;
    logic [7:0]  exp_rdata;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_b = 1'b1;
  always #5 clk = ~clk;

  ad_bus_if bus0 ();
  ad_bus_if bus1 ();

  ad_bus_master #(.ALE_CYCLES(A0), .WAIT_CYCLES(W0)) dut0 (.clk(clk), .rst_b(rst_b), .bus(bus0));
  ad_bus_master #(.ALE_CYCLES(A1), .WAIT_CYCLES(W1)) dut1 (.clk(clk), .rst_b(rst_b), .bus(bus1));

  // External transparent address latches.
  logic [7:0] latch0;
  logic [7:0] latch1;
  always_latch if (bus0.ale) latch0 <= bus0.ad_out;
  always_latch if (bus1.ale) latch1 <= bus1.ad_out;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  txn_t sb[$];

  txn_t       cur      [2];
  bit         in_txn   [2];
  int         acc_cyc  [2];
  int         acc_gap  [2];
  int         ale_cnt  [2];
  int         strb_cnt [2];
  int         rsp_seen [2];
  logic [4:0] bad      [2];

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d actual=%h required=%h", name, id, act, exp);
    end
  endtask

  task automatic flag(input string name, input int id);
    n_err++;
    $display("FAIL %s dut%0d at cycle %0d", name, id, cyc);
  endtask

  task automatic mon(input int id, input logic rv, input logic rr, input logic rsv,
                     input logic [7:0] rdata, input logic [7:0] aout, input logic oe,
                     input logic [7:0] ahi, input logic ale, input logic rdb, input logic wrb,
                     input logic [7:0] lat);
    txn_t t;
    if (!rst_b) begin
      in_txn[id] = 1'b0;
      return;
    end
    if (!rdb && !wrb)         flag("inv_rd_and_wr_low", id);
    if (oe && !rdb)           flag("inv_oe_during_read", id);
    if (ale && (!rdb || !wrb)) flag("inv_ale_with_strobe", id);
    if (rv && rr) begin
      acc_gap[id]  = cyc - acc_cyc[id];
      acc_cyc[id]  = cyc;
      ale_cnt[id]  = 0;
      strb_cnt[id] = 0;
      bad[id]      = '0;
      in_txn[id]   = 1'b1;
      if (sb.size() > 0) cur[id] = sb[0];
      else flag("accept_without_stimulus", id);
    end else if (in_txn[id]) begin
      if (ahi !== cur[id].addr[15:8]) bad[id][0] = 1'b1;
      if (ale) begin
        ale_cnt[id]++;
        if (aout !== cur[id].addr[7:0] || oe !== 1'b1) bad[id][1] = 1'b1;
      end
      if (cur[id].write) begin
        if (!wrb) begin
          strb_cnt[id]++;
          if (aout !== cur[id].wdata || oe !== 1'b1) bad[id][2] = 1'b1;
        end
        if (!rdb) bad[id][2] = 1'b1;
      end else begin
        if (!rdb) begin
          strb_cnt[id]++;
          if (oe !== 1'b0) bad[id][3] = 1'b1;
        end
        if (!wrb) bad[id][3] = 1'b1;
      end
      if ((!rdb || !wrb || rsv) && lat !== cur[id].addr[7:0]) bad[id][4] = 1'b1;
    end
    if (rsv) begin
      rsp_seen[id]++;
      if (!in_txn[id] || sb.size() == 0) begin
        flag("spurious_rsp_valid", id);
      end else begin
        t = sb.pop_front();
        chk("latency",       id, cyc - acc_cyc[id],  t.exp_lat);
        chk("rsp_rdata",     id, 32'(rdata),         32'(t.exp_rdata));
        chk("ale_cycles",    id, ale_cnt[id],        t.exp_ale);
        chk("strobe_cycles", id, strb_cnt[id],       t.exp_strb);
        chk("recover_ad_oe", id, 32'(oe),            32'(t.write));
        chk("bus_shape",     id, 32'(bad[id]),       32'd0);
        $display("txn dut%0d %s addr=%h wdata=%h rdata=%h lat=%0d", id,
                 t.write ? "WR" : "RD", t.addr, t.wdata, rdata, cyc - acc_cyc[id]);
      end
      in_txn[id] = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    mon(0, bus0.req_valid, bus0.req_ready, bus0.rsp_valid, bus0.rsp_rdata, bus0.ad_out,
        bus0.ad_oe, bus0.a_hi, bus0.ale, bus0.rd_b, bus0.wr_b, latch0);
    mon(1, bus1.req_valid, bus1.req_ready, bus1.rsp_valid, bus1.rsp_rdata, bus1.ad_out,
        bus1.ad_oe, bus1.a_hi, bus1.ale, bus1.rd_b, bus1.wr_b, latch1);
  end

  task automatic drive(input int id, input logic v, input logic w, input logic [15:0] a,
                       input logic [7:0] d, input logic [7:0] din);
    if (id == 0) begin
      bus0.req_valid = v; bus0.req_write = w; bus0.req_addr = a;
      bus0.req_wdata = d; bus0.ad_in = din;
    end else begin
      bus1.req_valid = v; bus1.req_write = w; bus1.req_addr = a;
      bus1.req_wdata = d; bus1.ad_in = din;
    end
  endtask

  function automatic logic ready(input int id);
    return (id == 0) ? bus0.req_ready : bus1.req_ready;
  endfunction

  task automatic push(input int id, input logic w, input logic [15:0] a, input logic [7:0] d,
                      input logic [7:0] er);
    txn_t t;
    t.id        = id;
    t.write     = w;
    t.addr      = a;
    t.wdata     = d;
    t.exp_rdata = er;
    t.exp_ale   = (id == 0) ? A0 : A1;
    t.exp_strb  = ((id == 0) ? W0 : W1) + 1;
    t.exp_lat   = t.exp_ale + t.exp_strb + 2;
    sb.push_back(t);
  endtask

  task automatic wait_ready(input int id, input string name);
    int k = 0;
    @(negedge clk);
    while (!ready(id) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (k >= 20) flag(name, id);
  endtask

  task automatic wait_drain(input int id);
    int k = 0;
    while (sb.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      flag("rsp_timeout", id);
      sb.delete();
    end
  endtask

  task automatic do_txn(input int id, input logic w, input logic [15:0] a, input logic [7:0] d,
                        input logic [7:0] din, input logic [7:0] er);
    @(posedge clk); #1;
    push(id, w, a, d, er);
    drive(id, 1'b1, w, a, d, din);
    wait_ready(id, "accept_timeout");
    @(posedge clk); #1;
    drive(id, 1'b0, w, a, d, din);
    wait_drain(id);
  endtask

  task automatic chk_reset(input int id);
    logic [5:0]  ctl;
    logic [23:0] dat;
    if (id == 0) begin
      ctl = {bus0.req_ready, bus0.rsp_valid, bus0.ad_oe, bus0.ale, bus0.rd_b, bus0.wr_b};
      dat = {bus0.rsp_rdata, bus0.ad_out, bus0.a_hi};
    end else begin
      ctl = {bus1.req_ready, bus1.rsp_valid, bus1.ad_oe, bus1.ale, bus1.rd_b, bus1.wr_b};
      dat = {bus1.rsp_rdata, bus1.ad_out, bus1.a_hi};
    end
    chk("reset_ctl",  id, 32'(ctl), 32'(6'b100011));
    chk("reset_data", id, 32'(dat), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    int rs;
    int n_busy;
    int k;

    vecs[0] = '{1'b1, 16'hC012, 8'h5A, 8'hEE, 8'h00};
    vecs[1] = '{1'b0, 16'h8001, 8'h00, 8'hA5, 8'hA5};
    vecs[2] = '{1'b1, 16'h0000, 8'hFF, 8'h11, 8'hA5};
    vecs[3] = '{1'b0, 16'hFFFF, 8'h00, 8'h3C, 8'h3C};
    vecs[4] = '{1'b0, 16'h1234, 8'h00, 8'h00, 8'h00};
    vecs[5] = '{1'b1, 16'hABCD, 8'h81, 8'h42, 8'h00};
    vecs[6] = '{1'b0, 16'h00FF, 8'h00, 8'h7E, 8'h7E};
    vecs[7] = '{1'b1, 16'hFF00, 8'h00, 8'h99, 8'h7E};

    for (int i = 0; i < 2; i++) begin
      acc_cyc[i] = 0; acc_gap[i] = 0; ale_cnt[i] = 0; strb_cnt[i] = 0;
      rsp_seen[i] = 0; bad[i] = '0; in_txn[i] = 1'b0;
    end
    drive(0, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 8'h0, 8'h0);

    // Asynchronous reset takes effect before the first clock edge.
    #1 rst_b = 1'b0;
    #2;
    chk_reset(0);
    chk_reset(1);
    @(posedge clk); #1 rst_b = 1'b1;
    repeat (2) @(posedge clk);

    for (int id = 0; id < 2; id++) begin
      for (int i = 0; i < 8; i++) begin
        do_txn(id, vecs[i].write, vecs[i].addr, vecs[i].wdata, vecs[i].rdin, vecs[i].exp_rdata);
      end
    end

    // Back-to-back: req_valid stays high across two requests.
    @(posedge clk); #1;
    push(0, 1'b1, 16'h1111, 8'h22, 8'h7E);
    drive(0, 1'b1, 1'b1, 16'h1111, 8'h22, 8'h00);
    wait_ready(0, "b2b_first_accept_timeout");
    @(posedge clk); #1;
    push(0, 1'b0, 16'h2222, 8'h00, 8'h99);
    drive(0, 1'b1, 1'b0, 16'h2222, 8'h00, 8'h99);
    n_busy = 0;
    k = 0;
    @(negedge clk);
    while (!bus0.req_ready && k < 20) begin
      n_busy++;
      @(negedge clk);
      k++;
    end
    chk("b2b_ready_low_cycles", 0, n_busy, 6);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h2222, 8'h00, 8'h99);
    wait_drain(0);
    chk("b2b_accept_gap", 0, acc_gap[0], 7);

    // Reset asserted mid-ACCESS of a write abandons it.
    @(posedge clk); #1;
    rs = rsp_seen[0];
    push(0, 1'b1, 16'h3C3C, 8'hE7, 8'h99);
    drive(0, 1'b1, 1'b1, 16'h3C3C, 8'hE7, 8'h00);
    wait_ready(0, "rst_accept_timeout");
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 16'h0, 8'h0, 8'hC3);
    k = 0;
    @(negedge clk);
    while (bus0.wr_b && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("rst_reached_access", 0, 32'(bus0.wr_b), 32'd0);
    #2 rst_b = 1'b0;
    #1;
    chk_reset(0);
    @(negedge clk);
    sb.delete();
    @(posedge clk); #1 rst_b = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_rsp_after_reset", 0, rsp_seen[0] - rs, 0);
    do_txn(0, 1'b0, 16'h5AA5, 8'h00, 8'hC3, 8'hC3);
    do_txn(0, 1'b1, 16'hC012, 8'h5A, 8'h00, 8'hC3);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "bench timed out");
  end

endmodule
